// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave register file.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BCNT_W = 3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_sync_filter.sv
// Synchroniser plus stability filter for one raw bus line; idles high.
module i2c_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // Metastability chain on the asynchronous input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  // Output follows the synchronised input only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= 1'b1;
      cnt  <= '0;
    end else if (synced == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
      dout <= synced;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a byte register file, auto-incrementing pointer and read support.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned REG_DEPTH   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  localparam int unsigned PTR_W      = $clog2(REG_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_data,
  output logic [7:0]       data_out,
  output logic             valid,
  output logic [PTR_W-1:0] wr_ptr,
  output logic             busy
);

  logic scl_f;
  logic sda_f;
  logic scl_q;
  logic sda_q;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_t              state;
  logic [BYTE_W-1:0]   shreg;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [PTR_W-1:0]    ptr;
  logic                rw;
  logic                ack_phase;
  logic [BYTE_W-1:0]   regs [REG_DEPTH];
  logic [BYTE_W-1:0]   rx_byte_c;

  i2c_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_filt (
    .clk   (clk),
    .reset (reset),
    .din   (scl_in),
    .dout  (scl_f)
  );

  i2c_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_filt (
    .clk   (clk),
    .reset (reset),
    .din   (sda_in),
    .dout  (sda_f)
  );

  // Byte as it will look once the bit present on SDA at this SCL rise is shifted in.
  assign rx_byte_c = {shreg[6:0], sda_q};

  // Register-file read port for the local host; a same-cycle bus write shows next cycle.
  assign host_data = regs[host_addr];

  // Registered SCL edges and START/STOP conditions from the filtered lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_q     <= scl_f;
      sda_q     <= sda_f;
      scl_rise  <= scl_f & ~scl_q;
      scl_fall  <= ~scl_f & scl_q;
      start_det <= scl_f & scl_q & sda_q & ~sda_f;
      stop_det  <= scl_f & scl_q & ~sda_q & sda_f;
    end
  end

  // Protocol FSM, shift register, pointer, register file and host-visible strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      wr_ptr    <= '0;
      shreg     <= '0;
      bit_cnt   <= BCNT_W'(7);
      ptr       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      for (int unsigned i = 0; i < REG_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      valid <= 1'b0;
      if (stop_det) begin
        state     <= IDLE;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        busy      <= 1'b1;
        sda_oe    <= 1'b0;
        bit_cnt   <= BCNT_W'(7);
        ack_phase <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end

          ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte_c;
              bit_cnt <= bit_cnt - BCNT_W'(1);
              if (bit_cnt == '0) begin
                if (rx_byte_c[7:1] == SLAVE_ADDR) begin
                  state     <= ADDR_ACK;
                  rw        <= rx_byte_c[0];
                  ack_phase <= 1'b0;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end

          PTR: begin
            if (scl_rise) begin
              shreg   <= rx_byte_c;
              bit_cnt <= bit_cnt - BCNT_W'(1);
              if (bit_cnt == '0) begin
                ptr       <= rx_byte_c[PTR_W-1:0];
                state     <= PTR_ACK;
                ack_phase <= 1'b0;
              end
            end
          end

          WRITE: begin
            if (scl_rise) begin
              shreg   <= rx_byte_c;
              bit_cnt <= bit_cnt - BCNT_W'(1);
              if (bit_cnt == '0) begin
                regs[ptr] <= rx_byte_c;
                data_out  <= rx_byte_c;
                wr_ptr    <= ptr;
                valid     <= 1'b1;
                ptr       <= ptr + PTR_W'(1);
                state     <= WRITE_ACK;
                ack_phase <= 1'b0;
              end
            end
          end

          // First SCL fall after the byte pulls SDA low; the next fall ends the ACK clock.
          ADDR_ACK, PTR_ACK, WRITE_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= ~I2C_ACK;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= BCNT_W'(7);
                if (state == ADDR_ACK && rw) begin
                  state  <= READ;
                  shreg  <= regs[ptr];
                  sda_oe <= ~regs[ptr][7];
                end else begin
                  state  <= (state == ADDR_ACK) ? PTR : WRITE;
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          // MSB was presented on entry; each fall presents the next bit, then releases.
          READ: begin
            if (scl_fall) begin
              if (bit_cnt == '0) begin
                sda_oe    <= 1'b0;
                state     <= READ_ACK;
                ack_phase <= 1'b0;
              end else begin
                sda_oe  <= ~shreg[bit_cnt - BCNT_W'(1)];
                bit_cnt <= bit_cnt - BCNT_W'(1);
              end
            end
          end

          // Master ACK advances the pointer and the following fall reloads the next byte.
          READ_ACK: begin
            if (scl_rise) begin
              if (sda_q == I2C_ACK) begin
                ptr       <= ptr + PTR_W'(1);
                ack_phase <= 1'b1;
              end else begin
                state <= WAIT_STOP;
              end
            end else if (scl_fall && ack_phase) begin
              state     <= READ;
              ack_phase <= 1'b0;
              bit_cnt   <= BCNT_W'(7);
              shreg     <= regs[ptr];
              sda_oe    <= ~regs[ptr][7];
            end
          end

          WAIT_STOP: begin
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Randomised bench for i2c_slave_regfile against a transaction-level register-file model.
module tb_i2c_slave_regfile;

  localparam int unsigned PTR_W = 4;
  localparam int unsigned DEPTH = 16;

  logic             clk;
  logic             rst_n;
  logic             scl_m;
  logic             sda_m;
  logic             sda_oe;
  logic [PTR_W-1:0] host_addr;
  logic [7:0]       host_data;
  logic [7:0]       data_out;
  logic             valid;
  logic [PTR_W-1:0] wr_ptr;
  logic             busy;
  logic             sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regfile #(
    .SLAVE_ADDR  (7'h50),
    .REG_DEPTH   (DEPTH),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .host_addr (host_addr),
    .host_data (host_data),
    .data_out  (data_out),
    .valid     (valid),
    .wr_ptr    (wr_ptr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mregs [DEPTH];
  int          mptr;
  logic [11:0] exp_q [$];
  logic [11:0] obs_q [$];
  logic [7:0]  wq [$];
  int          oe_cnt = 0;

  // Observe write strobes and any SDA drive away from the clock edge.
  always @(negedge clk) begin
    if (valid) obs_q.push_back({wr_ptr, data_out});
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; wait_clk(10);
    scl_m = 1'b1; wait_clk(10);
    sda_m = 1'b0; wait_clk(10);
    scl_m = 1'b0; wait_clk(10);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wait_clk(10);
    scl_m = 1'b1; wait_clk(10);
    sda_m = 1'b1; wait_clk(15);
  endtask

  task automatic wbit(input logic b);
    sda_m = b;    wait_clk(10);
    scl_m = 1'b1; wait_clk(20);
    scl_m = 1'b0; wait_clk(10);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; wait_clk(10);
    scl_m = 1'b1; wait_clk(10);
    b = sda_line; wait_clk(10);
    scl_m = 1'b0; wait_clk(10);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    logic [7:0] t;
    t = '0;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      t[i] = b;
    end
    d = t;
    wbit(ack);
  endtask

  task automatic check_valids(input string tag);
    check({tag, "_nvalid"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_strobe"}, 32'(obs_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic scan_regs(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      host_addr = PTR_W'(i);
      #1;
      check({tag, "_reg"}, 32'(host_data), 32'(mregs[i]));
    end
  endtask

  // Write transaction: pointer byte then the bytes queued in wq.
  task automatic tx_write(input string tag, input logic [7:0] p);
    logic ack;
    bus_start;
    check({tag, "_busy_hi"}, 32'(busy), 1);
    wbyte(8'hA0, ack); check({tag, "_addr_ack"}, 32'(ack), 0);
    wbyte(p, ack);     check({tag, "_ptr_ack"}, 32'(ack), 0);
    mptr = int'(p) % DEPTH;
    foreach (wq[i]) begin
      wbyte(wq[i], ack);
      check({tag, "_data_ack"}, 32'(ack), 0);
      mregs[mptr] = wq[i];
      exp_q.push_back({PTR_W'(mptr), wq[i]});
      mptr = (mptr + 1) % DEPTH;
    end
    bus_stop;
    check({tag, "_busy_lo"}, 32'(busy), 0);
    check_valids(tag);
    wq.delete();
  endtask

  // Read transaction, optionally preceded by a pointer write and repeated START.
  task automatic tx_read(input string tag, input bit set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    bus_start;
    if (set_ptr) begin
      wbyte(8'hA0, ack); check({tag, "_waddr_ack"}, 32'(ack), 0);
      wbyte(p, ack);     check({tag, "_ptr_ack"}, 32'(ack), 0);
      mptr = int'(p) % DEPTH;
      bus_start;
    end
    wbyte(8'hA1, ack); check({tag, "_raddr_ack"}, 32'(ack), 0);
    for (int i = 0; i < n; i++) begin
      rbyte(d, (i == n - 1) ? 1'b1 : 1'b0);
      check({tag, "_rdata"}, 32'(d), 32'(mregs[mptr]));
      if (i != n - 1) mptr = (mptr + 1) % DEPTH;
    end
    check({tag, "_oe_after_nack"}, 32'(sda_oe), 0);
    bus_stop;
    check({tag, "_busy_lo"}, 32'(busy), 0);
    check_valids(tag);
  endtask

  initial begin
    logic ack;
    int   oe_before;
    int   op;
    int   n;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; host_addr = '0;
    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;
    mptr = 0;
    wait_clk(5);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_wr_ptr", 32'(wr_ptr), 0);
    rst_n = 1'b1;
    wait_clk(10);
    scan_regs("rst");

    // Directed write, then a pointer wrap.
    wq = '{8'hA5, 8'h5A};
    tx_write("t1", 8'h03);
    check("t1_data_out", 32'(data_out), 32'h5A);
    check("t1_wr_ptr", 32'(wr_ptr), 4);
    wq = '{8'h11, 8'h22};
    tx_write("t2", 8'h0F);
    scan_regs("t2");

    // Pointer write, repeated START, two-byte read.
    tx_read("t3", 1'b1, 8'h03, 2);

    // Foreign address: never acknowledged, SDA never driven.
    oe_before = oe_cnt;
    bus_start;
    wbyte(8'hA2, ack); check("t4_addr_nack", 32'(ack), 1);
    wbyte(8'hFF, ack); check("t4_data_nack", 32'(ack), 1);
    bus_stop;
    check("t4_oe_count", 32'(oe_cnt), 32'(oe_before));
    check_valids("t4");
    scan_regs("t4");

    // Reset while the slave is pulling SDA for an address ACK.
    bus_start;
    for (int i = 7; i >= 0; i--) wbit(i == 0 ? 1'b0 : ((8'hA0 >> i) & 1));
    wait_clk(2);
    check("t5a_oe_acking", 32'(sda_oe), 1);
    #2 rst_n = 1'b0;
    #1 check("t5a_oe_async", 32'(sda_oe), 0);
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    obs_q.delete();

    // Reset during the 4th data bit of a write.
    bus_start;
    wbyte(8'hA0, ack); wbyte(8'h05, ack);
    wbit(1'b1); wbit(1'b1); wbit(1'b0);
    sda_m = 1'b0; wait_clk(10);
    scl_m = 1'b1; wait_clk(5);
    #2 rst_n = 1'b0;
    #1 check("t5_oe_async", 32'(sda_oe), 0);
    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;
    mptr = 0;
    obs_q.delete();
    wait_clk(2);
    check("t5_busy", 32'(busy), 0);
    check("t5_valid", 32'(valid), 0);
    check("t5_data_out", 32'(data_out), 0);
    check("t5_wr_ptr", 32'(wr_ptr), 0);
    scan_regs("t5");
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    tx_read("t5_rd0", 1'b0, 8'h00, 1);
    wq = '{8'h3C};
    tx_write("t5_wr", 8'h02);
    tx_read("t5_rd", 1'b1, 8'h02, 1);

    // SCL glitch mid-bit, STOP after four data bits.
    bus_start;
    wbyte(8'hA0, ack); check("t6_addr_ack", 32'(ack), 0);
    wbyte(8'h07, ack); check("t6_ptr_ack", 32'(ack), 0);
    mptr = 7;
    sda_m = 1'b1; wait_clk(5);
    scl_m = 1'b1; wait_clk(1);
    scl_m = 1'b0; wait_clk(4);
    scl_m = 1'b1; wait_clk(20);
    scl_m = 1'b0; wait_clk(10);
    wbit(1'b0); wbit(1'b1); wbit(1'b1);
    bus_stop;
    check("t6_busy", 32'(busy), 0);
    check_valids("t6");
    scan_regs("t6");

    // A full byte with a glitch in its third bit still lands intact.
    bus_start;
    wbyte(8'hA0, ack); wbyte(8'h09, ack);
    mptr = 9;
    wbit(1'b1); wbit(1'b0);
    sda_m = 1'b1; wait_clk(5);
    scl_m = 1'b1; wait_clk(1);
    scl_m = 1'b0; wait_clk(4);
    scl_m = 1'b1; wait_clk(20);
    scl_m = 1'b0; wait_clk(10);
    for (int i = 4; i >= 0; i--) wbit((8'h0D >> i) & 1);
    rbit(ack); check("t6b_ack", 32'(ack), 0);
    mregs[9] = 8'hAD;
    exp_q.push_back({PTR_W'(9), 8'hAD});
    bus_stop;
    check_valids("t6b");
    scan_regs("t6b");

    // Randomised mix of writes and reads against the model.
    for (int it = 0; it < 14; it++) begin
      op = int'($urandom_range(0, 2));
      n  = int'($urandom_range(1, 3));
      if (op == 0) begin
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
        tx_write("rnd_wr", 8'($urandom));
      end else if (op == 1) begin
        tx_read("rnd_rdp", 1'b1, 8'($urandom), n);
      end else begin
        tx_read("rnd_rdc", 1'b0, 8'h00, n);
      end
    end
    scan_regs("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
